// File: rtl/phase_pdm_shaper.sv
// phase_pdm_shaper: selectable waveform, click-free gain ramp and first-order sigma-delta (PDM) output
// Ports: clk, rst_n (async active-low); phase (accumulator word, top SAMPLE_WIDTH bits used);
// wave_sel (00 saw, 01 square, 10 triangle, 11 pulse 25%); volume/mute (ramp target);
// pdm_out (1-bit bitstream); gain_cur (applied gain 0..15); busy (gain ramp in progress).
// Optional: define PDM_DITHER_EN to add 2-bit LFSR dither into the modulator sum.
module phase_pdm_shaper #(
    parameter int PHASE_WIDTH    = 24,
    parameter int SAMPLE_WIDTH   = 8,
    parameter int RAMP_DIV_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PHASE_WIDTH-1:0] phase,
    input  logic [1:0]             wave_sel,
    input  logic [3:0]             volume,
    input  logic                   mute,
    output logic                   pdm_out,
    output logic [3:0]             gain_cur,
    output logic                   busy
);
    localparam int SW = SAMPLE_WIDTH;
    localparam logic [RAMP_DIV_WIDTH-1:0] CNT_ONE = 1;
    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;
    state_t                    state_q, state_d;
    logic [RAMP_DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [3:0]                gain_q, gain_d, tgt;
    logic                      busy_q, pdm_q, pdm_d, tick, unused_ok;
    logic [SW-1:0]             p, tri_w, s1_q, s1_d, s2_q, s2_d, err_q, err_d;
    logic [SW+3:0]             prod;
    assign p     = phase[PHASE_WIDTH-1 -: SW];
    assign tri_w = {p[SW-2:0], 1'b0};
    assign s1_d  = (wave_sel == 2'b00) ? p :
                   (wave_sel == 2'b01) ? {SW{p[SW-1]}} :
                   (wave_sel == 2'b10) ? (p[SW-1] ? ~tri_w : tri_w) :
                                         {SW{&p[SW-1:SW-2]}};
    assign prod  = s1_q * gain_q;
    assign s2_d  = prod[SW+3:4];
`ifdef PDM_DITHER_EN
    logic [15:0]   lfsr_q, lfsr_d;
    logic [SW+1:0] sum;
    // Galois form of x^16+x^14+x^13+x^11+1, shifting right
    assign lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
    assign sum    = {2'b00, err_q} + {2'b00, s2_q} + {{SW{1'b0}}, lfsr_q[1:0]};
    assign pdm_d  = |sum[SW+1:SW];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= 16'hACE1;
        else        lfsr_q <= lfsr_d;
    end
`else
    logic [SW:0] sum;
    assign sum   = {1'b0, err_q} + {1'b0, s2_q};
    assign pdm_d = sum[SW];
`endif
    assign err_d     = sum[SW-1:0];
    assign unused_ok = ^{phase[PHASE_WIDTH-SW-1:0], prod[3:0]};
    assign tgt  = mute ? 4'd0 : volume;
    assign tick = &cnt_q;
    // Direction is re-derived from the post-step gain every cycle, so a target
    // reversal flips UP/DOWN while the divider keeps counting.
    always_comb begin
        gain_d  = gain_q;
        state_d = state_q;
        cnt_d   = '0;
        if (state_q == IDLE) begin
            state_d = (tgt > gain_q) ? UP : (tgt < gain_q) ? DOWN : IDLE;
        end else begin
            gain_d  = (!tick || tgt == gain_q) ? gain_q :
                      (tgt > gain_q) ? gain_q + 4'd1 : gain_q - 4'd1;
            state_d = (tgt > gain_d) ? UP : (tgt < gain_d) ? DOWN : IDLE;
            cnt_d   = (state_d == IDLE) ? '0 : cnt_q + CNT_ONE;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gain_q  <= '0;
            busy_q  <= 1'b0;
            s1_q    <= '0;
            s2_q    <= '0;
            err_q   <= '0;
            pdm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gain_q  <= gain_d;
            busy_q  <= (state_q != IDLE);
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            err_q   <= err_d;
            pdm_q   <= pdm_d;
        end
    end
    assign pdm_out  = pdm_q;
    assign gain_cur = gain_q;
    assign busy     = busy_q;
endmodule
